// File: rtl/dmem_responder.sv
// dmem_responder
//   Multi-cycle word-addressed data memory that answers the MEM-stage
//   load/store interface. A request is latched in IDLE, held for LATENCY
//   ACCESS cycles, committed on the last ACCESS edge and acknowledged with a
//   one-cycle mem_ready pulse. stall holds the upstream pipeline while a
//   request is outstanding. Misaligned (non-word) addresses are rejected with
//   mem_err together with mem_ready so the pipeline is released.
//
// Parameters
//   DEPTH      number of 32-bit words (power of two, >= 4)
//   LATENCY    ACCESS-state cycles per transfer (>= 1)
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous active-low reset
//   memread     load request, level, held until mem_ready
//   memwrite    store request, level, held until mem_ready (wins over memread)
//   addr        byte address; bits [log2(DEPTH)+1:2] select the word
//   write_data  store data
//   read_data   registered load result, held until the next load completes
//   mem_ready   one-cycle pulse, access complete (or rejected)
//   stall       combinational, high while a request waits for mem_ready
//   mem_err     one-cycle pulse, misaligned access rejected
module dmem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        mem_ready,
  output logic        stall,
  output logic        mem_err
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE,
    S_ERR
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              lat_write;
  logic [AW-1:0]     lat_idx;
  logic [31:0]       lat_data;
  logic              commit_write;

  logic [31:0]       mem [DEPTH];

  // Upper address bits are deliberately ignored: addresses wrap modulo DEPTH.
  logic              unused_addr_bits;
  assign unused_addr_bits = ^addr[31:AW+2];

  assign stall = (memread | memwrite) & ~mem_ready;

  // Control and the latched request. mem_ready / mem_err are registered and
  // asserted on the edge that enters DONE / ERR, so they last one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      read_data <= '0;
      mem_ready <= 1'b0;
      mem_err   <= 1'b0;
      lat_write <= 1'b0;
      lat_idx   <= '0;
      lat_data  <= '0;
    end else begin
      mem_ready <= 1'b0;
      mem_err   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (memread | memwrite) begin
            if (addr[1:0] == 2'b00) begin
              state     <= S_ACCESS;
              cnt       <= CNT_W'(LATENCY - 1);
              lat_write <= memwrite;
              lat_idx   <= addr[AW+1:2];
              lat_data  <= write_data;
            end else begin
              state     <= S_ERR;
              mem_ready <= 1'b1;
              mem_err   <= 1'b1;
            end
          end
        end
        S_ACCESS: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            state     <= S_DONE;
            mem_ready <= 1'b1;
            if (!lat_write) begin
              read_data <= mem[lat_idx];
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        S_ERR:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Array is not reset; a reset during ACCESS returns state to IDLE before
  // the commit edge, so an aborted write never lands.
  assign commit_write = (state == S_ACCESS) && (cnt == '0) && lat_write;

  always_ff @(posedge clk) begin
    if (commit_write) begin
      mem[lat_idx] <= lat_data;
    end
  end

endmodule
